// File: rtl/line_follower_pkg.sv
// Shared definitions for the line-follower robot: motor command codes,
// the ASCII bytes the voice module sends, and the command decoder.
package line_follower_pkg;

  // Motor command codes (shared with the motor block)
  localparam logic [2:0] CMD_AUTO  = 3'b000;
  localparam logic [2:0] CMD_FWD   = 3'b001;
  localparam logic [2:0] CMD_RIGHT = 3'b010;
  localparam logic [2:0] CMD_LEFT  = 3'b011;
  localparam logic [2:0] CMD_STOP  = 3'b100;
  localparam logic [2:0] CMD_REV   = 3'b101;

  // ASCII bytes emitted by the voice recognition module
  localparam logic [7:0] ASCII_F = 8'h46;
  localparam logic [7:0] ASCII_R = 8'h52;
  localparam logic [7:0] ASCII_L = 8'h4C;
  localparam logic [7:0] ASCII_S = 8'h53;
  localparam logic [7:0] ASCII_B = 8'h42;
  localparam logic [7:0] ASCII_A = 8'h41;

  // UART receiver states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  // Result of decoding one received byte
  typedef struct packed {
    logic       hit;
    logic [2:0] code;
  } cmd_dec_t;

  // Map a received byte to a command; hit=0 for bytes we do not know.
  function automatic cmd_dec_t decode_cmd(input logic [7:0] b);
    cmd_dec_t d;
    d.hit  = 1'b1;
    d.code = CMD_AUTO;
    case (b)
      ASCII_F: d.code = CMD_FWD;
      ASCII_R: d.code = CMD_RIGHT;
      ASCII_L: d.code = CMD_LEFT;
      ASCII_S: d.code = CMD_STOP;
      ASCII_B: d.code = CMD_REV;
      ASCII_A: d.code = CMD_AUTO;
      default: d.hit  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchroniser, framing FSM and bit timer.
// byte_ok / frame_err are single-cycle strobes asserted in the stop-bit
// sample cycle; rx_byte holds the assembled byte while byte_ok is high.
module uart_rx_byte
  import line_follower_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       frame_err
);

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  // First sample lands mid start bit, later ones one bit period apart
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   rx_s;

  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;

  // Synchroniser chain: stage 0 takes the raw line, each later stage the one before
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = rx;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign rx_s    = sync_reg[SYNC_STAGES-1];
  assign rx_byte = shift_reg;

  // Synchroniser flops, preset to idle-high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= '1;
    else     sync_reg <= sync_next;
  end

  // Receiver state, bit timer, bit index and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  // Framing: next state, timer reload/decrement and result strobes
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    byte_ok    = 1'b0;
    frame_err  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_reg == '0) begin
          if (rx_s) begin
            state_next = IDLE;            // too short to be a start bit
          end else begin
            state_next = DATA;
            cnt_next   = FULL_LOAD;
            bit_next   = 3'd0;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_reg == '0) begin
          shift_next = {rx_s, shift_reg[7:1]};   // LSB arrives first
          cnt_next   = FULL_LOAD;
          if (bit_reg == 3'd7) state_next = STOP;
          else                 bit_next   = bit_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_reg == '0) begin
          if (rx_s) begin
            byte_ok    = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err  = 1'b1;
            state_next = WAIT_IDLE;       // ride out a break before rearming
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/voice_cmd_rx.sv
// Voice command receiver: turns UART bytes from the voice module into a
// registered motor command, and reverts to auto after a hold period with
// no fresh recognised command.
module voice_cmd_rx
  import line_follower_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int BAUD    = 9600,
  parameter int HOLD_MS = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       timeout
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HOLD_CYC     = HOLD_MS * (CLK_HZ / 1000);
  localparam int HOLD_W       = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

  logic [7:0]  rx_byte;
  logic        byte_ok;
  logic        byte_err;
  cmd_dec_t    dec;
  logic        load;
  logic        expire;

  logic [2:0]        cmd_reg, cmd_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic              valid_reg, valid_next;
  logic              ferr_reg, ferr_next;
  logic              tout_reg, tout_next;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .byte_ok  (byte_ok),
    .frame_err(byte_err)
  );

  assign cmd       = cmd_reg;
  assign cmd_valid = valid_reg;
  assign frame_err = ferr_reg;
  assign timeout   = tout_reg;

  // Command, hold timer and output pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_reg   <= CMD_AUTO;
      hold_reg  <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      tout_reg  <= 1'b0;
    end else begin
      cmd_reg   <= cmd_next;
      hold_reg  <= hold_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
      tout_reg  <= tout_next;
    end
  end

  // Decode and hold timer; a fresh command beats an expiry in the same cycle
  always_comb begin
    dec        = decode_cmd(rx_byte);
    load       = byte_ok && dec.hit;
    expire     = (cmd_reg != CMD_AUTO) && (hold_reg == '0);
    cmd_next   = cmd_reg;
    hold_next  = hold_reg;
    valid_next = 1'b0;
    tout_next  = 1'b0;
    ferr_next  = byte_err;
    if (load) begin
      cmd_next   = dec.code;
      hold_next  = HOLD_LOAD;
      valid_next = 1'b1;
    end else if (expire) begin
      cmd_next  = CMD_AUTO;
      tout_next = 1'b1;
    end else if (cmd_reg != CMD_AUTO) begin
      hold_next = hold_reg - HOLD_W'(1);   // hold_reg is non-zero here
    end
  end

endmodule

// File: tb/tb_voice_cmd_rx.sv
// Directed bench for voice_cmd_rx at 16 clocks per bit and a 160-cycle hold.
module tb_voice_cmd_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       frame_err;
  logic       timeout;

  always #5 clk = ~clk;

  voice_cmd_rx #(
    .CLK_HZ (16000),
    .BAUD   (1000),
    .HOLD_MS(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .frame_err(frame_err),
    .timeout  (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int n_valid = 0, n_tout = 0, n_ferr = 0;
  int valid_cyc = 0, tout_cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (cmd_valid) begin
      n_valid   = n_valid + 1;
      valid_cyc = cyc;
    end
    if (timeout) begin
      n_tout   = n_tout + 1;
      tout_cyc = cyc;
    end
    if (frame_err) n_ferr = n_ferr + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one 8N1 frame; extra_low keeps the line low after a zero stop bit
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int extra_low);
    start_cyc = cyc;
    $display("tx byte 0x%02h stop=%0b extra_low=%0d start_cyc=%0d", b, stop_bit, extra_low, cyc);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop_bit;
    repeat (16) @(negedge clk);
    repeat (extra_low) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_tout(input string tag, input int target, input int budget);
    int n = 0;
    while (n_tout < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, n_tout, target);
  endtask

  int v0, t0, f0, v_l, v_f;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("rst_cmd",   int'(cmd), 0);
    check_eq("rst_valid", int'(cmd_valid), 0);
    check_eq("rst_ferr",  int'(frame_err), 0);
    check_eq("rst_tout",  int'(timeout), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 'F' -> forward, cmd_valid 155 cycles after the start edge is driven
    send_byte(8'h46, 1'b1, 0);
    check_eq("f_cmd",     int'(cmd), 1);
    check_eq("f_nvalid",  n_valid, 1);
    check_eq("f_latency", valid_cyc - start_cyc, 155);
    check_eq("f_nferr",   n_ferr, 0);

    // No further bytes: auto after exactly 160 cycles
    wait_tout("f_tout_wait", 1, 400);
    check_eq("f_tout_delay", tout_cyc - valid_cyc, 160);
    check_eq("f_tout_cmd",   int'(cmd), 0);
    repeat (20) @(negedge clk);

    // 'L' then back-to-back 'Z': Z ignored even while the hold expires
    send_byte(8'h4C, 1'b1, 0);
    check_eq("l_cmd", int'(cmd), 3);
    v_l = valid_cyc;
    send_byte(8'h5A, 1'b1, 0);
    check_eq("z_nvalid", n_valid, 2);
    wait_tout("l_tout_wait", 2, 200);
    check_eq("l_tout_delay", tout_cyc - v_l, 160);
    repeat (20) @(negedge clk);

    // 'R' with a zero stop bit and a 40-cycle low line
    v0 = n_valid; t0 = n_tout; f0 = n_ferr;
    send_byte(8'h52, 1'b0, 24);
    check_eq("r_nferr",  n_ferr, f0 + 1);
    check_eq("r_cmd",    int'(cmd), 0);
    check_eq("r_nvalid", n_valid, v0);
    check_eq("r_ntout",  n_tout, t0);
    repeat (10) @(negedge clk);
    send_byte(8'h53, 1'b1, 0);
    check_eq("s_cmd",    int'(cmd), 4);
    check_eq("s_nvalid", n_valid, v0 + 1);

    // 5-cycle glitch is rejected
    v0 = n_valid; f0 = n_ferr; t0 = n_tout;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("gl_cmd",    int'(cmd), 4);
    check_eq("gl_nvalid", n_valid, v0);
    check_eq("gl_nferr",  n_ferr, f0);

    // Reset in the middle of the data bits of 'B'
    $display("tx partial 0x42 then reset at cyc=%0d", cyc);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b0; repeat (16) @(negedge clk);
    rx = 1'b1; repeat (16) @(negedge clk);
    rx = 1'b0; repeat (16) @(negedge clk);
    rx = 1'b0; repeat (8) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("mr_cmd", int'(cmd), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("mr_nvalid", n_valid, v0);
    check_eq("mr_nferr",  n_ferr, f0);
    check_eq("mr_ntout",  n_tout, t0);
    send_byte(8'h42, 1'b1, 0);
    check_eq("b_cmd",     int'(cmd), 5);
    check_eq("b_latency", valid_cyc - start_cyc, 155);
    wait_tout("b_tout_wait", t0 + 1, 400);
    repeat (20) @(negedge clk);

    // 'F' then 'S' back-to-back: S load lands on the F expiry cycle
    t0 = n_tout;
    send_byte(8'h46, 1'b1, 0);
    v_f = valid_cyc;
    send_byte(8'h53, 1'b1, 0);
    check_eq("col_cmd",   int'(cmd), 4);
    check_eq("col_delay", valid_cyc - v_f, 160);
    check_eq("col_ntout", n_tout, t0);
    wait_tout("col_tout_wait", t0 + 1, 400);
    check_eq("col_tout_delay", tout_cyc - valid_cyc, 160);
    check_eq("col_end_cmd", int'(cmd), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
